// File: rtl/vga_timing_pkg.sv
// Shared timing types and default 640x480@60 raster parameters.
package vga_timing_pkg;

  // One axis of a raster: visible span followed by front porch, sync and back porch.
  typedef struct packed {
    logic [31:0] active;
    logic [31:0] fp;
    logic [31:0] sync;
    logic [31:0] bp;
  } timing_t;

  localparam timing_t VGA_640X480_H = '{active: 32'd640, fp: 32'd16, sync: 32'd96, bp: 32'd48};
  localparam timing_t VGA_640X480_V = '{active: 32'd480, fp: 32'd10, sync: 32'd2, bp: 32'd33};

  localparam int unsigned CNT_W_DEF = 12;

  // Total period of one axis in strobes (pixels) or lines.
  function automatic int unsigned timing_total(timing_t t);
    return int'(t.active + t.fp + t.sync + t.bp);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator and the fetch/DAC consumers.
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 12
);
  logic             pixel_en;
  logic             fetch_en;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
  logic             hsync;
  logic             vsync;
  logic             active;
  logic             vblank;

  modport master (
    input  pixel_en,
    output fetch_en, x, y, line_start, frame_start, hsync, vsync, active, vblank
  );

  modport slave (
    output pixel_en,
    input  fetch_en, x, y, line_start, frame_start, hsync, vsync, active, vblank
  );
endinterface

// File: rtl/vga_pipe_delay.sv
// Enable-gated shift register with a reset value supplied on a port; DEPTH=0 is a wire.
module vga_pipe_delay #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_pipe;
    assign unused_pipe = ^{clk_i, rst_i, en_i, rst_val_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];

    // Shift one stage per enable, hold otherwise.
    always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) sr_d[i] = sr_q[i];
      if (en_i) begin
        sr_d[0] = d_i;
        for (int i = 1; i < int'(DEPTH); i++) sr_d[i] = sr_q[i-1];
      end
    end

    // Stage registers; reset flushes every stage to the idle level.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(DEPTH); i++) sr_q[i] <= rst_val_i;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) sr_q[i] <= sr_d[i];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: early fetch coordinates plus delayed sync/blank.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_640X480_H.active,
  parameter int unsigned H_FP       = VGA_640X480_H.fp,
  parameter int unsigned H_SYNC     = VGA_640X480_H.sync,
  parameter int unsigned H_BP       = VGA_640X480_H.bp,
  parameter int unsigned V_ACTIVE   = VGA_640X480_V.active,
  parameter int unsigned V_FP       = VGA_640X480_V.fp,
  parameter int unsigned V_SYNC     = VGA_640X480_V.sync,
  parameter int unsigned V_BP       = VGA_640X480_V.bp,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input logic              clock,
  input logic              reset,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_field
    $error("vga_timing_gen: every timing field must be non-zero");
  end
  if (64'(H_TOTAL) >= (64'd1 << CNT_W) || 64'(V_TOTAL) >= (64'd1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W");
  end
  if (PIPE_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Delayed vector layout: {hsync, vsync, active, vblank}.
  localparam logic [3:0] SYNC_RST = {~HSYNC_POL, ~VSYNC_POL, 2'b00};

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             fetch_en_q, fetch_en_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [3:0]       sync0_q, sync0_d;
  logic [3:0]       sync_out;
  logic             visible, hs_on, vs_on, vblank_raw;

  // Decode the current counter position.
  always_comb begin
    visible    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_on      = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_on      = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    vblank_raw = (v_cnt_q >= V_ACT_C);
  end

  // Counter advance and stage-0 capture, both gated by the pixel strobe.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    fetch_en_d    = fetch_en_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    sync0_d       = sync0_q;
    if (vid.pixel_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
      fetch_en_d    = visible;
      x_d           = visible ? h_cnt_q : '0;
      y_d           = visible ? v_cnt_q : '0;
      line_start_d  = visible && (h_cnt_q == '0);
      frame_start_d = visible && (h_cnt_q == '0) && (v_cnt_q == '0);
      sync0_d       = {hs_on ? HSYNC_POL : ~HSYNC_POL,
                       vs_on ? VSYNC_POL : ~VSYNC_POL,
                       visible, vblank_raw};
    end
  end

  // Counter and stage-0 registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      fetch_en_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync0_q       <= SYNC_RST;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fetch_en_q    <= fetch_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      sync0_q       <= sync0_d;
    end
  end

  // Align sync/blank with the fetch latency of the downstream pixel path.
  vga_pipe_delay #(
    .WIDTH (4),
    .DEPTH (PIPE_DELAY)
  ) u_pipe (
    .clk_i     (clock),
    .rst_i     (reset),
    .en_i      (vid.pixel_en),
    .rst_val_i (SYNC_RST),
    .d_i       (sync0_q),
    .q_o       (sync_out)
  );

  assign vid.fetch_en    = fetch_en_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.hsync       = sync_out[3];
  assign vid.vsync       = sync_out[2];
  assign vid.active      = sync_out[1];
  assign vid.vblank      = sync_out[0];

endmodule
